// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR consumer: widths, FSM states and the generator's init pattern.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 16;

  // Power-on pattern of the generator; bench models use it to reason about warm-up.
  localparam logic [LFSR_WIDTH-1:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2,
    FAILED  = 2'd3
  } reader_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr_word_reader_if.sv
// Word delivery bus of the LFSR reader.
// Handshake: a word transfers on every rising edge where out_valid && out_ready; while
// out_valid is high and no transfer happens, out_data holds stable (a source failure may drop it).
interface lfsr_word_reader_if #(
  parameter int WORD_WIDTH = 32
);

  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/lfsr_word_reader_repetition_count_monitor.sv
// Repetition-count health test: flags the source as stuck once STUCK_LIMIT identical bits in a row are seen.
module repetition_count_monitor #(
  parameter int STUCK_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  output logic stuck
);

  localparam int RUN_W = $clog2(STUCK_LIMIT + 1);

  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next;
  logic             last_bit;
  logic             stuck_q;

  // run == 0 only before the first sample, so that sample always starts a run of one.
  always_comb begin
    run_next = RUN_W'(1);
    if (run != '0 && bit_in == last_bit) begin
      run_next = (run == RUN_W'(STUCK_LIMIT)) ? run : run + RUN_W'(1);
    end
  end

  // Combinational on the edge the limit is reached so the FSM reacts on that same edge.
  assign stuck = stuck_q | (run_next == RUN_W'(STUCK_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= '0;
      last_bit <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      run      <= run_next;
      last_bit <= bit_in;
      stuck_q  <= stuck;
    end
  end

endmodule

// File: rtl/lfsr_word_reader.sv
// Samples the whitening LFSR only after a full refresh, packs chunks into words and delivers them
// over valid/ready; a repetition-count health test locks the output off when the source is stuck.
module lfsr_word_reader
  import lfsr_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int REFRESH_CYCLES = 16,
  parameter int WARMUP_CYCLES  = 16,
  parameter int STUCK_LIMIT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LFSR_WIDTH-1:0] lfsr_in,
  input  logic                  random_bit,
  output logic                  health_fail,
  output reader_state_t         dbg_state,
  lfsr_word_reader_if.master    bus
);

  localparam int CHUNKS  = WORD_WIDTH / LFSR_WIDTH;
  localparam int CNT_W   = $clog2(max_int(REFRESH_CYCLES, WARMUP_CYCLES) + 1);
  localparam int CHUNK_W = $clog2(CHUNKS + 1);

  reader_state_t         state;
  logic [CNT_W-1:0]      warm_cnt;
  logic [CNT_W-1:0]      refresh_cnt;
  logic [CHUNK_W-1:0]    chunk_cnt;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  fail_q;
  logic                  stuck;
  logic [WORD_WIDTH-1:0] capture_word;

  repetition_count_monitor #(
    .STUCK_LIMIT(STUCK_LIMIT)
  ) u_rct (
    .clk   (clk),
    .rst   (rst),
    .bit_in(random_bit),
    .stuck (stuck)
  );

  // Oldest chunk drifts toward the MSBs as newer chunks are shifted in.
  assign capture_word = (data_q << LFSR_WIDTH) | WORD_WIDTH'(lfsr_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WARMUP;
      warm_cnt    <= '0;
      refresh_cnt <= '0;
      chunk_cnt   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else if (stuck) begin
      // Failure overrides everything, including an in-flight handshake or final capture.
      state   <= FAILED;
      fail_q  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        WARMUP: begin
          warm_cnt <= warm_cnt + CNT_W'(1);
          if (warm_cnt == CNT_W'(WARMUP_CYCLES - 1)) begin
            state       <= COLLECT;
            refresh_cnt <= '0;
            chunk_cnt   <= '0;
          end
        end
        COLLECT: begin
          if (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
            chunk_cnt   <= chunk_cnt + CHUNK_W'(1);
            data_q      <= capture_word;
            if (chunk_cnt == CHUNK_W'(CHUNKS - 1)) begin
              valid_q <= 1'b1;
              state   <= PRESENT;
            end
          end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
          end
        end
        PRESENT: begin
          if (bus.out_ready) begin
            valid_q     <= 1'b0;
            state       <= COLLECT;
            refresh_cnt <= '0;
            chunk_cnt   <= '0;
          end
        end
        FAILED: begin
          valid_q <= 1'b0;
          fail_q  <= 1'b1;
        end
        default: state <= FAILED;
      endcase
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign health_fail   = fail_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_lfsr_word_reader.sv
// Self-checking bench for lfsr_word_reader: directed vector table, hand-written corner sequences
// and randomized traffic compared every edge against a timeline-based reference model.
module tb_lfsr_word_reader;
  import lfsr_pkg::*;

  localparam int WW     = 32;
  localparam int R      = 16;
  localparam int WU     = 16;
  localparam int LIM    = 64;
  localparam int CHUNKS = WW / 16;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   lfsr_in = '0;
  logic          random_bit = 1'b0;
  logic          health_fail;
  reader_state_t dbg_state;

  lfsr_word_reader_if #(.WORD_WIDTH(WW)) bus();

  lfsr_word_reader #(
    .WORD_WIDTH    (WW),
    .REFRESH_CYCLES(R),
    .WARMUP_CYCLES (WU),
    .STUCK_LIMIT   (LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lfsr_in    (lfsr_in),
    .random_bit (random_bit),
    .health_fail(health_fail),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            edge_n;
  int            word_start;
  logic [15:0]   chunk_q[$];
  logic          bit_hist[$];
  logic          m_valid;
  logic          m_fail;
  logic [WW-1:0] m_data;
  logic [WW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_reset();
    edge_n     = 0;
    word_start = WU;
    chunk_q.delete();
    bit_hist.delete();
    m_valid = 1'b0;
    m_fail  = 1'b0;
    m_data  = '0;
  endtask

  // Timeline model: a word starts at word_start, chunks are taken every R edges after it,
  // the source is bad when the last LIM raw bits are all identical.
  task automatic model_edge();
    logic same;
    edge_n++;
    bit_hist.push_back(random_bit);
    if (bit_hist.size() > LIM) void'(bit_hist.pop_front());
    same = (bit_hist.size() == LIM);
    for (int i = 0; i < bit_hist.size(); i++)
      if (bit_hist[i] !== bit_hist[0]) same = 1'b0;
    if (m_fail) begin
      m_valid = 1'b0;
    end else if (same) begin
      m_fail  = 1'b1;
      m_valid = 1'b0;
      m_data  = '0;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid    = 1'b0;
        word_start = edge_n;
        chunk_q.delete();
      end
    end else if (edge_n > word_start && (edge_n - word_start) % R == 0) begin
      chunk_q.push_back(lfsr_in);
      m_data = (m_data << 16) | WW'(lfsr_in);
      if (chunk_q.size() == CHUNKS) begin
        m_valid = 1'b1;
        exp_q.push_back(m_data);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", WW'(bus.out_valid), WW'(m_valid));
    chk("data", bus.out_data, m_data);
    chk("health_fail", WW'(health_fail), WW'(m_fail));
  endtask

  // Asserts rst between edges and checks the asynchronous clear before any clock edge.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", WW'(bus.out_valid), '0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_fail", WW'(health_fail), '0);
    chk("rst_state", WW'(dbg_state), WW'(WARMUP));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    int            at_edge;
    logic          exp_valid;
    logic          chk_data;
    logic [WW-1:0] exp_data;
  } vec_t;

  vec_t tbl[10];
  bit   seen[logic [15:0]];

  initial begin
    int   vi;
    int   words;
    int   last_hs;
    int   seq;
    logic prev_valid;

    tbl[0] = '{1,  1'b0, 1'b1, 32'h0000_0000};
    tbl[1] = '{16, 1'b0, 1'b1, 32'h0000_0000};
    tbl[2] = '{31, 1'b0, 1'b1, 32'h0000_0000};
    tbl[3] = '{32, 1'b0, 1'b1, 32'h0000_1111};
    tbl[4] = '{47, 1'b0, 1'b1, 32'h0000_1111};
    tbl[5] = '{48, 1'b1, 1'b1, 32'h1111_2222};
    tbl[6] = '{49, 1'b0, 1'b1, 32'h1111_2222};
    tbl[7] = '{64, 1'b0, 1'b1, 32'h1111_2222};
    tbl[8] = '{80, 1'b0, 1'b0, 32'h0000_0000};
    tbl[9] = '{81, 1'b1, 1'b0, 32'h0000_0000};

    bus.out_ready = 1'b0;
    apply_reset();

    // Test 1: first word timing and chunk order.
    vi = 0;
    for (int e = 1; e <= 81; e++) begin
      lfsr_in       = (e <= 32) ? 16'h1111 : (e <= 48) ? 16'h2222 : 16'($urandom);
      random_bit    = e[0];
      bus.out_ready = 1'b1;
      step();
      if (vi < 10 && tbl[vi].at_edge == e) begin
        chk("t1_valid", WW'(bus.out_valid), WW'(tbl[vi].exp_valid));
        if (tbl[vi].chk_data) chk("t1_data", bus.out_data, tbl[vi].exp_data);
        vi++;
      end
    end
    chk("t1_vectors_applied", WW'(vi), WW'(10));

    // Test 2: back-pressure holds the word while the LFSR keeps moving.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      lfsr_in    = 16'($urandom);
      random_bit = ~random_bit;
      step();
      chk("t2_hold_valid", WW'(bus.out_valid), WW'(1));
    end
    bus.out_ready = 1'b1;
    random_bit    = ~random_bit;
    step();
    chk("t2_release", WW'(bus.out_valid), '0);
    last_hs = edge_n;

    // Test 3: back-to-back words with unique chunk values and random raw bits.
    exp_q.delete();
    seen.delete();
    words = 0;
    seq   = 1;
    for (int i = 0; i < 600 && words < 10; i++) begin
      lfsr_in    = 16'(seq * 7 + 3);
      seq++;
      random_bit = 1'($urandom_range(0, 1));
      step();
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("t3_unexpected_word", bus.out_data, '0);
        end else begin
          chk("t3_word", bus.out_data, exp_q.pop_front());
        end
        chk("t3_gap", WW'(edge_n - last_hs), WW'(CHUNKS * R));
        for (int c = 0; c < CHUNKS; c++) begin
          logic [15:0] ch;
          ch = bus.out_data[c*16 +: 16];
          chk("t3_chunk_reuse", WW'(seen.exists(ch)), '0);
          seen[ch] = 1'b1;
        end
        last_hs = edge_n + 1;
        words++;
      end
    end
    chk("t3_word_count", WW'(words), WW'(10));

    // Test 4: 63 identical bits pass, 64 identical bits fail and latch.
    apply_reset();
    random_bit = 1'b0;
    step();
    for (int i = 0; i < 63; i++) begin
      random_bit    = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("t4_63_ok", WW'(health_fail), '0);
    for (int i = 0; i < 20; i++) begin
      random_bit = i[0];
      step();
    end
    for (int i = 1; i <= 64; i++) begin
      random_bit    = 1'b0;
      bus.out_ready = 1'($urandom_range(0, 1));
      step();
      if (i == 63) chk("t4_before_limit", WW'(health_fail), '0);
    end
    chk("t4_fail_set", WW'(health_fail), WW'(1));
    chk("t4_valid_low", WW'(bus.out_valid), '0);
    for (int i = 0; i < 200; i++) begin
      random_bit = ~random_bit;
      lfsr_in    = 16'($urandom);
      step();
    end
    chk("t4_latched", WW'(health_fail), WW'(1));

    // Test 5: failure lands on the same edge as a handshake inside PRESENT.
    apply_reset();
    for (int e = 1; e <= 104; e++) begin
      random_bit    = (e <= 40) ? e[0] : 1'b1;
      bus.out_ready = (e >= 104);
      lfsr_in       = 16'($urandom);
      step();
      if (e == 103) begin
        chk("t5_pre_valid", WW'(bus.out_valid), WW'(1));
        chk("t5_pre_fail", WW'(health_fail), '0);
      end
    end
    chk("t5_valid", WW'(bus.out_valid), '0);
    chk("t5_fail", WW'(health_fail), WW'(1));
    chk("t5_state", WW'(dbg_state), WW'(FAILED));
    prev_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      random_bit = ~random_bit;
      step();
      prev_valid = prev_valid | bus.out_valid;
    end
    chk("t5_no_new_word", WW'(prev_valid), '0);

    // Test 6: async reset out of FAILED, then the first word again at edge 48.
    apply_reset();
    for (int e = 1; e <= 48; e++) begin
      random_bit    = e[0];
      bus.out_ready = 1'b1;
      lfsr_in       = 16'($urandom);
      step();
      if (e == 47) chk("t6_not_early", WW'(bus.out_valid), '0);
    end
    chk("t6_first_word", WW'(bus.out_valid), WW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
